// File: rtl/reduce_tree_pkg.sv
// Shared types and elaboration-time helpers for pipelined_reduce_tree and
// its per-level adder sub-module.
package reduce_tree_pkg;

  localparam int unsigned BEATS_WIDTH = 16;

  typedef struct packed {
    logic valid;
    logic last;
    logic acc_en;
  } side_t;

  function automatic int unsigned tree_levels(input int unsigned n);
    int unsigned l;
    l = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) l = i + 1;
    end
    return l;
  endfunction

  function automatic int unsigned tree_latency(input int unsigned n, input int unsigned reg_every);
    return (tree_levels(n) + reg_every - 1) / reg_every;
  endfunction

  // Lane count after `level` pairwise levels (odd leftovers survive).
  function automatic int unsigned lanes_at(input int unsigned n, input int unsigned level);
    return (n + (32'd1 << level) - 1) >> level;
  endfunction

  function automatic bit level_registered(input int unsigned level_no, input int unsigned levels,
                                          input int unsigned reg_every);
    return ((level_no % reg_every) == 0) || (level_no == levels);
  endfunction

endpackage

// File: rtl/reduce_tree_level.sv
// One level of the reduction tree: pairwise adds with odd-lane pass-through,
// optional output register. Sign extension when PIPELINED_REDUCE_TREE_SIGNED_EN.
module reduce_tree_level
  import reduce_tree_pkg::*;
#(
  parameter int unsigned N_IN       = 2,
  parameter int unsigned W_IN       = 32,
  parameter int unsigned W_OUT      = W_IN + 1,
  parameter bit          REGISTERED = 1'b1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  side_t                               in_side,
  input  logic [N_IN*W_IN-1:0]                in_data,
  output side_t                               out_side,
  output logic [((N_IN + 1) / 2)*W_OUT-1:0]   out_data
);

  localparam int unsigned N_OUT = (N_IN + 1) / 2;
  localparam int unsigned PAIRS = N_IN / 2;

  function automatic logic [W_OUT-1:0] widen(input logic [W_IN-1:0] x);
`ifdef PIPELINED_REDUCE_TREE_SIGNED_EN
    return W_OUT'($signed(x));
`else
    return W_OUT'(x);
`endif
  endfunction

  logic [N_OUT*W_OUT-1:0] data_d;
  side_t                  side_d;

  always_comb begin
    data_d = '0;
    side_d = in_side;
    for (int unsigned i = 0; i < PAIRS; i++) begin
      data_d[i*W_OUT +: W_OUT] = widen(in_data[(2*i)*W_IN +: W_IN])
                               + widen(in_data[(2*i+1)*W_IN +: W_IN]);
    end
    if ((N_IN % 2) == 1) begin
      data_d[(N_OUT-1)*W_OUT +: W_OUT] = widen(in_data[(N_IN-1)*W_IN +: W_IN]);
    end
  end

  if (REGISTERED) begin : g_reg
    side_t                  side_q;
    logic [N_OUT*W_OUT-1:0] data_q;

    always_ff @(posedge clk) begin
      if (reset) side_q <= '0;
      else       side_q <= side_d;
      data_q <= data_d;
    end

    assign out_side = side_q;
    assign out_data = data_q;
  end else begin : g_comb
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
    assign out_side = side_d;
    assign out_data = data_d;
  end

endmodule

// File: rtl/pipelined_reduce_tree.sv
// Pipelined N-lane adder tree with cross-beat group accumulation.
// Optional macro PIPELINED_REDUCE_TREE_SIGNED_EN: two's-complement lanes and signed overflow.
module pipelined_reduce_tree
  import reduce_tree_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned WIDTH_IN  = 32,
  parameter int unsigned REG_EVERY = 1,
  parameter int unsigned ACC_WIDTH = 48
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [N-1:0][WIDTH_IN-1:0]       in_vector,
  input  logic                             in_last,
  input  logic                             acc_en,
  output logic                             out_valid,
  output logic [ACC_WIDTH-1:0]             out_sum,
  output logic [BEATS_WIDTH-1:0]           out_beats,
  output logic                             out_overflow
);

  localparam int unsigned LEVELS = tree_levels(N);
  localparam int unsigned TW     = WIDTH_IN + LEVELS;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned NI = lanes_at(N, k);
    localparam int unsigned NO = lanes_at(N, k + 1);
    localparam int unsigned WI = WIDTH_IN + k;

    side_t              side_in;
    side_t              side_out;
    logic [NI*WI-1:0]   data_in;
    logic [NO*(WI+1)-1:0] data_out;

    if (k == 0) begin : g_src
      assign side_in = '{valid: in_valid, last: in_last, acc_en: acc_en};
      assign data_in = in_vector;
    end else begin : g_src
      assign side_in = g_lvl[k-1].side_out;
      assign data_in = g_lvl[k-1].data_out;
    end

    reduce_tree_level #(
      .N_IN      (NI),
      .W_IN      (WI),
      .W_OUT     (WI + 1),
      .REGISTERED(level_registered(k + 1, LEVELS, REG_EVERY))
    ) u_level (
      .clk     (clk),
      .reset   (reset),
      .in_side (side_in),
      .in_data (data_in),
      .out_side(side_out),
      .out_data(data_out)
    );
  end

  side_t                  tree_side;
  logic [TW-1:0]          tree_sum;
  logic [ACC_WIDTH-1:0]   tree_ext;
  logic [ACC_WIDTH-1:0]   group_sum;
  logic                   wrap;

  assign tree_side = g_lvl[LEVELS-1].side_out;
  assign tree_sum  = g_lvl[LEVELS-1].data_out;

  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [BEATS_WIDTH-1:0] beats_q, beats_d;
  logic                   sticky_q, sticky_d;
  logic                   out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]   out_sum_q, out_sum_d;
  logic [BEATS_WIDTH-1:0] out_beats_q, out_beats_d;
  logic                   out_ovf_q, out_ovf_d;

`ifdef PIPELINED_REDUCE_TREE_SIGNED_EN
  assign tree_ext  = ACC_WIDTH'($signed(tree_sum));
  assign group_sum = acc_q + tree_ext;
  assign wrap      = (acc_q[ACC_WIDTH-1] == tree_ext[ACC_WIDTH-1])
                  && (group_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
`else
  assign tree_ext          = ACC_WIDTH'(tree_sum);
  assign {wrap, group_sum} = {1'b0, acc_q} + {1'b0, tree_ext};
`endif

  always_comb begin
    acc_d       = acc_q;
    beats_d     = beats_q;
    sticky_d    = sticky_q;
    out_valid_d = 1'b0;
    out_sum_d   = out_sum_q;
    out_beats_d = out_beats_q;
    out_ovf_d   = out_ovf_q;
    if (tree_side.valid) begin
      if (tree_side.last || !tree_side.acc_en) begin
        out_valid_d = 1'b1;
        out_sum_d   = group_sum;
        out_beats_d = (beats_q == '1) ? beats_q : beats_q + BEATS_WIDTH'(1);
        out_ovf_d   = sticky_q | wrap;
        acc_d       = '0;
        beats_d     = '0;
        sticky_d    = 1'b0;
      end else begin
        acc_d    = group_sum;
        beats_d  = (beats_q == '1) ? beats_q : beats_q + BEATS_WIDTH'(1);
        sticky_d = sticky_q | wrap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      beats_q     <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_beats_q <= out_beats_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_sum      = out_sum_q;
  assign out_beats    = out_beats_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_pipelined_reduce_tree.sv
// Self-checking bench for pipelined_reduce_tree: six configurations, a
// per-instance scoreboard of expected results tagged with their due cycle.
module tb_pipelined_reduce_tree;

`ifdef PIPELINED_REDUCE_TREE_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  localparam int unsigned NINST = 6;

  typedef struct {
    logic [63:0] sum;
    logic [15:0] beats;
    logic        ovf;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic [7:0][31:0] lanes;
    logic [63:0]      sum;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic last = 1'b0;
  logic acc_en = 1'b0;
  logic [NINST-1:0] iv = '0;

  logic [7:0][31:0] lv0 = '0;
  logic [4:0][31:0] lv1 = '0;
  logic [4:0][31:0] lv2 = '0;
  logic [1:0][31:0] lv3 = '0;
  logic [3:0][31:0] lv4 = '0;
  logic [3:0][7:0]  lv5 = '0;

  logic [NINST-1:0] ov, oo;
  logic [15:0] ob [NINST];
  logic [47:0] os0, os1, os2, os4, os5;
  logic [35:0] os3;

  int unsigned cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  exp_t sbq [NINST][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_reduce_tree #(.N(8), .WIDTH_IN(32), .REG_EVERY(1), .ACC_WIDTH(48)) u_n8 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_vector(lv0), .in_last(last), .acc_en(acc_en),
    .out_valid(ov[0]), .out_sum(os0), .out_beats(ob[0]), .out_overflow(oo[0]));
  pipelined_reduce_tree #(.N(5), .WIDTH_IN(32), .REG_EVERY(1), .ACC_WIDTH(48)) u_n5 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_vector(lv1), .in_last(last), .acc_en(acc_en),
    .out_valid(ov[1]), .out_sum(os1), .out_beats(ob[1]), .out_overflow(oo[1]));
  pipelined_reduce_tree #(.N(5), .WIDTH_IN(32), .REG_EVERY(2), .ACC_WIDTH(48)) u_n5r2 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_vector(lv2), .in_last(last), .acc_en(acc_en),
    .out_valid(ov[2]), .out_sum(os2), .out_beats(ob[2]), .out_overflow(oo[2]));
  pipelined_reduce_tree #(.N(2), .WIDTH_IN(32), .REG_EVERY(1), .ACC_WIDTH(36)) u_n2 (
    .clk(clk), .reset(reset), .in_valid(iv[3]), .in_vector(lv3), .in_last(last), .acc_en(acc_en),
    .out_valid(ov[3]), .out_sum(os3), .out_beats(ob[3]), .out_overflow(oo[3]));
  pipelined_reduce_tree #(.N(4), .WIDTH_IN(32), .REG_EVERY(1), .ACC_WIDTH(48)) u_n4 (
    .clk(clk), .reset(reset), .in_valid(iv[4]), .in_vector(lv4), .in_last(last), .acc_en(acc_en),
    .out_valid(ov[4]), .out_sum(os4), .out_beats(ob[4]), .out_overflow(oo[4]));
  pipelined_reduce_tree #(.N(4), .WIDTH_IN(8), .REG_EVERY(1), .ACC_WIDTH(48)) u_n4w8 (
    .clk(clk), .reset(reset), .in_valid(iv[5]), .in_vector(lv5), .in_last(last), .acc_en(acc_en),
    .out_valid(ov[5]), .out_sum(os5), .out_beats(ob[5]), .out_overflow(oo[5]));

  function automatic int unsigned lat(input int unsigned id);
    case (id)
      0, 1:    return 4;
      3:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [63:0] mask(input int unsigned id);
    return (id == 3) ? (64'd1 << 36) - 64'd1 : (64'd1 << 48) - 64'd1;
  endfunction

  // Flat reference sum of the first n lanes, each w bits wide.
  function automatic logic [63:0] lsum(input logic [7:0][31:0] l, input int unsigned n,
                                       input int unsigned w);
    logic [63:0] acc, x;
    acc = '0;
    for (int unsigned i = 0; i < n; i++) begin
      x = {32'b0, l[i]} & ((64'd1 << w) - 64'd1);
      if (SGN && x[w-1]) x = x | ~((64'd1 << w) - 64'd1);
      acc = acc + x;
    end
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    iv = '0;
  endtask

  task automatic beat(input int unsigned id, input logic [7:0][31:0] l, input logic lst,
                      input logic ae);
    tick();
    last   = lst;
    acc_en = ae;
    iv[id] = 1'b1;
    case (id)
      0: lv0 = l;
      1: lv1 = l[4:0];
      2: lv2 = l[4:0];
      3: lv3 = l[1:0];
      4: lv4 = l[3:0];
      default: for (int i = 0; i < 4; i++) lv5[i] = l[i][7:0];
    endcase
  endtask

  task automatic push(input int unsigned id, input logic [63:0] s, input logic [15:0] b,
                      input logic o);
    exp_t e;
    e.sum   = s & mask(id);
    e.beats = b;
    e.ovf   = o;
    e.cyc   = cyc + lat(id);
    sbq[id].push_back(e);
  endtask

  task automatic check_out(input int unsigned id, input logic v, input logic [63:0] s,
                           input logic [15:0] b, input logic o);
    exp_t e;
    if (v !== 1'b1) return;
    n_vec++;
    if (sbq[id].size() == 0) begin
      n_bad++;
      $display("FAIL inst%0d unexpected out_valid at cycle %0d: sum=%h beats=%0d ovf=%b",
               id, cyc, s, b, o);
      return;
    end
    e = sbq[id].pop_front();
    if (s !== e.sum || b !== e.beats || o !== e.ovf || cyc !== e.cyc) begin
      n_bad++;
      $display("FAIL inst%0d result: got sum=%h beats=%0d ovf=%b cycle=%0d, want sum=%h beats=%0d ovf=%b cycle=%0d",
               id, s, b, o, cyc, e.sum, e.beats, e.ovf, e.cyc);
    end
  endtask

  task automatic rz(input int unsigned id, input logic v, input logic [63:0] s,
                    input logic [15:0] b, input logic o);
    n_vec++;
    if (v !== 1'b0 || s !== 64'd0 || b !== 16'd0 || o !== 1'b0) begin
      n_bad++;
      $display("FAIL inst%0d reset state: got valid=%b sum=%h beats=%0d ovf=%b, want all zero",
               id, v, s, b, o);
    end
  endtask

  initial begin
    vec_t             tbl [8];
    logic [7:0][31:0] l, l2;
    logic [63:0]      b2;

    fork
      forever begin
        @(negedge clk);
        check_out(0, ov[0], 64'(os0), ob[0], oo[0]);
        check_out(1, ov[1], 64'(os1), ob[1], oo[1]);
        check_out(2, ov[2], 64'(os2), ob[2], oo[2]);
        check_out(3, ov[3], 64'(os3), ob[3], oo[3]);
        check_out(4, ov[4], 64'(os4), ob[4], oo[4]);
        check_out(5, ov[5], 64'(os5), ob[5], oo[5]);
      end
    join_none

    for (int i = 0; i < 8; i++) tbl[0].lanes[i] = 32'(i + 1);
    tbl[0].sum = 64'd36;
    tbl[1].lanes = '0;
    tbl[1].sum = 64'd0;
    tbl[2].lanes = '1;
    tbl[2].sum = SGN ? 64'hFFFF_FFFF_FFFF_FFF8 : 64'h7_FFFF_FFF8;
    for (int i = 0; i < 8; i++) tbl[3].lanes[i] = i[0] ? 32'h7FFF_FFFF : 32'h8000_0000;
    tbl[3].sum = SGN ? 64'hFFFF_FFFF_FFFF_FFFC : 64'h3_FFFF_FFFC;
    for (int j = 4; j < 8; j++) begin
      for (int i = 0; i < 8; i++) tbl[j].lanes[i] = $urandom;
      tbl[j].sum = lsum(tbl[j].lanes, 8, 32);
    end

    repeat (3) tick();
    rz(0, ov[0], 64'(os0), ob[0], oo[0]);
    rz(1, ov[1], 64'(os1), ob[1], oo[1]);
    rz(2, ov[2], 64'(os2), ob[2], oo[2]);
    rz(3, ov[3], 64'(os3), ob[3], oo[3]);
    rz(4, ov[4], 64'(os4), ob[4], oo[4]);
    rz(5, ov[5], 64'(os5), ob[5], oo[5]);
    reset = 1'b0;

    // back-to-back single-beat groups, in_last deliberately toggled
    for (int j = 0; j < 8; j++) begin
      beat(0, tbl[j].lanes, j[0], 1'b0);
      push(0, tbl[j].sum, 16'd1, 1'b0);
    end
    repeat (6) tick();

    l = '0;
    for (int i = 0; i < 5; i++) l[i] = 32'(10 * (i + 1));
    beat(1, l, 1'b1, 1'b0); push(1, 64'd150, 16'd1, 1'b0);
    beat(2, l, 1'b1, 1'b0); push(2, 64'd150, 16'd1, 1'b0);
    repeat (6) tick();

    for (int i = 0; i < 8; i++) l[i] = 32'd1;
    for (int k = 0; k < 4; k++) beat(0, l, k == 3, 1'b1);
    push(0, 64'd32, 16'd4, 1'b0);
    for (int i = 0; i < 8; i++) l2[i] = 32'd2;
    beat(0, l2, 1'b1, 1'b1); push(0, 64'd16, 16'd1, 1'b0);
    beat(0, l, 1'b0, 1'b1);
    beat(0, l, 1'b0, 1'b0); push(0, 64'd16, 16'd2, 1'b0);
    repeat (6) tick();

    l = '0;
    l[0] = 32'hFFFF_FFFF;
    l[1] = 32'hFFFF_FFFF;
    b2 = lsum(l, 2, 32);
    l2 = '0;
    l2[0] = 32'd1;
    l2[1] = 32'd2;
    for (int k = 0; k < 9; k++) beat(3, l, k == 8, 1'b1);
    push(3, b2 * 64'd9, 16'd9, !SGN);
    beat(3, l2, 1'b1, 1'b0); push(3, 64'd3, 16'd1, 1'b0);
    for (int k = 0; k < 10; k++) beat(3, l, k == 9, 1'b1);
    push(3, b2 * 64'd10, 16'd10, !SGN);
    beat(3, l2, 1'b0, 1'b0); push(3, 64'd3, 16'd1, 1'b0);
    repeat (6) tick();

    l = '0;
    l[0] = 32'hFF;
    l[1] = 32'hFE;
    l[2] = 32'h03;
    l[3] = 32'hFC;
    beat(5, l, 1'b1, 1'b0);
    push(5, SGN ? 64'hFFFF_FFFF_FFFF_FFFC : 64'd764, 16'd1, 1'b0);
    repeat (6) tick();

    // open group of two beats on the N=4 instance, then a one-cycle reset
    for (int i = 0; i < 4; i++) l[i] = 32'd5;
    beat(4, l, 1'b0, 1'b1);
    beat(4, l, 1'b0, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rz(0, ov[0], 64'(os0), ob[0], oo[0]);
    rz(4, ov[4], 64'(os4), ob[4], oo[4]);
    for (int i = 0; i < 4; i++) l[i] = 32'd3;
    beat(4, l, 1'b0, 1'b0); push(4, 64'd12, 16'd1, 1'b0);
    repeat (8) tick();

    for (int unsigned id = 0; id < NINST; id++) begin
      n_vec++;
      if (sbq[id].size() != 0) begin
        n_bad++;
        $display("FAIL inst%0d missing outputs: got %0d pending, want 0", id, sbq[id].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

endmodule
